serial_add_ctrl: RTL and testbench
==================================

Name: serial_add_ctrl

Overview:
- Bit-serial adder controller. Sequences a single one-bit full-adder cell over W cycles to add two W-bit operands LSB-first.
- Provides a start/busy/done handshake and a registered result.
- Sits between a requesting FSM or testbench driver and the shared one-bit full-adder cell. Trades latency for area against a W-bit ripple adder.

Parameters:
- W, 4, operand/result width in bits; legal range W >= 1.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE or DONE.
- a  input  W  operand A; captured when start is accepted.
- b  input  W  operand B; captured when start is accepted.
- ci  input  1  carry-in; captured when start is accepted.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; result valid.
- sum  output  W  registered result; holds until the next completion or reset.
- co  output  1  registered carry-out; holds like sum.

Behaviour:
- Clocking and reset:
  - Single clock domain (clk). Reset rst is synchronous and active-high.
  - Reset values: state=IDLE, busy=0, done=0, sum=0, co=0. Internal shift registers, carry flop and bit counter are also cleared.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 → capture a and b into shift registers, ci into the carry flop, bit counter=0, go to RUN.
  - start=0 → stay in IDLE.
- RUN (busy=1):
  - Each cycle, the FA inputs are (a_sh[0], b_sh[0], carry).
  - FA sum bit shifts into the MSB of the result shift register (shift right). a_sh and b_sh shift right.
  - carry <= FA carry-out. Counter increments.
  - When the counter = W-1 on a clock edge, go to DONE. On that same edge, load sum <= completed result and co <= final carry.
- DONE (done=1, busy=0, exactly one cycle):
  - start=1 → accept a new operation exactly as in IDLE and go to RUN. done still pulses this cycle and sum/co are unchanged.
  - start=0 → go to IDLE.
- Latency:
  - start sampled at edge t0.
  - RUN occupies edges t1..tW.
  - done is high in the cycle following edge tW, i.e. W+1 cycles after start is sampled.
  - Sustained throughput: one result per W+1 cycles.
- start while in RUN: ignored. No queueing, no effect on the operation in flight.
- Operand inputs a, b, ci: may change freely after acceptance. Only the values captured at acceptance are used.
- Arithmetic: {co,sum} = a + b + ci, modulo 2^(W+1). This matches a W-bit ripple adder exactly.
- W=1: RUN lasts one cycle. The counter must not overflow or wrap; its width is max(1, clog2(W)).
- Reset mid-RUN: abort immediately to IDLE. Partial results are discarded, sum/co are cleared and no done pulse is issued.
- rst and start high together: rst wins.

Optional Feature:
- Macro: SERIAL_ADD_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit), registered alongside sum. Reset 0.
  - ovf = two's-complement signed overflow = (carry into MSB) XOR (carry out of MSB), captured on the final RUN cycle.
  - Holds with sum. Cleared on reset.
- Undefined: the ovf port and its logic are absent. All other behaviour is identical.

Test Plan:
- W=4, a=5, b=3, ci=0, start pulsed → busy high 4 cycles; done pulses at cycle 5 after start; sum=8, co=0.
- W=4, a=15, b=1, ci=0 → sum=0, co=1. Then a=7, b=8, ci=1 → sum=0, co=1.
- Start held high during RUN with different operands (a=1, b=1) → ignored. First result unaffected; new operation begins only in the DONE cycle.
- Back-to-back: start held continuously with a=2, b=2 then a=9, b=9 presented on the DONE cycle:
  - done pulses every 5 cycles; results sum=4, co=0 then sum=2, co=1.
  - busy drops for exactly one cycle between operations.
- rst asserted on the 2nd RUN cycle of a=6, b=6 → next cycle state IDLE, busy=0, sum=0, co=0, and no done pulse.
- With SERIAL_ADD_OVF_EN, W=4:
  - a=7, b=1, ci=0 → sum=8, co=0, ovf=1.
  - a=15, b=1, ci=0 → sum=0, co=1, ovf=0.
  - a=8, b=8, ci=0 → sum=0, co=1, ovf=1.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder cell stepped LSB-first over W cycles.
// Optional signed-overflow output enabled by defining SERIAL_ADD_OVF_EN.
module serial_add_ctrl #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         co
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  a_sh_q, a_sh_d;
  logic [W-1:0]  b_sh_q, b_sh_d;
  logic [W-1:0]  r_sh_q, r_sh_d;
  logic          carry_q, carry_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  sum_q, sum_d;
  logic          co_q, co_d;
  logic          fa_s, fa_c;
  logic [W-1:0]  r_next;
`ifdef SERIAL_ADD_OVF_EN
  logic          ovf_q, ovf_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      r_sh_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      co_q    <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      r_sh_q  <= r_sh_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      co_q    <= co_d;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  // The shared full-adder cell.
  always_comb begin
    fa_s = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
    fa_c = (a_sh_q[0] & b_sh_q[0]) | (carry_q & (a_sh_q[0] ^ b_sh_q[0]));
    r_next = r_sh_q >> 1;
    r_next[W-1] = fa_s;
  end

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    r_sh_d  = r_sh_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    co_d    = co_q;
`ifdef SERIAL_ADD_OVF_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          r_sh_d  = '0;
          carry_d = ci;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        r_sh_d  = r_next;
        carry_d = fa_c;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          // Counter parks at zero so W=1 never wraps past its range.
          cnt_d   = '0;
          sum_d   = r_next;
          co_d    = fa_c;
`ifdef SERIAL_ADD_OVF_EN
          ovf_d   = carry_q ^ fa_c;
`endif
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign co   = co_q;
`ifdef SERIAL_ADD_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Randomized bench for serial_add_ctrl; reference result is plain integer addition.
module tb_serial_add_ctrl;
  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst, start, ci;
  logic [W-1:0] a, b;
  logic         busy, done, co;
  logic [W-1:0] sum;
`ifdef SERIAL_ADD_OVF_EN
  logic         ovf;
  logic         exp_ovf;
`endif

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [W-1:0] exp_sum;
  logic         exp_co;

  serial_add_ctrl #(.W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .ci(ci),
    .busy(busy), .done(done), .sum(sum), .co(co)
`ifdef SERIAL_ADD_OVF_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_held(input string tag);
    check({tag, "_sum"}, 32'(sum), 32'(exp_sum));
    check({tag, "_co"}, 32'(co), 32'(exp_co));
`ifdef SERIAL_ADD_OVF_EN
    check({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
`endif
  endtask

  // Reference: {co,sum} = a+b+ci; signed overflow when the signed sum leaves range.
  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mci);
    int unsigned total;
`ifdef SERIAL_ADD_OVF_EN
    int ssum;
`endif
    total = int'(ma) + int'(mb) + int'(mci);
    exp_sum = W'(total);
    exp_co  = (total >= (1 << W));
`ifdef SERIAL_ADD_OVF_EN
    ssum = int'($signed(ma)) + int'($signed(mb)) + int'(mci);
    exp_ovf = (ssum > (1 << (W - 1)) - 1) || (ssum < -(1 << (W - 1)));
`endif
  endtask

  // Entered in IDLE or DONE with inputs free; leaves the DUT in DONE with start=0.
  task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic oci,
                        input bit noisy);
    logic [W-1:0] ha, hb;
    logic hco;
`ifdef SERIAL_ADD_OVF_EN
    logic hovf;
    hovf = exp_ovf;
`endif
    ha = exp_sum; hco = exp_co; hb = ob;
    start = 1'b1; a = oa; b = ob; ci = oci;
    tick();
    for (int unsigned i = 0; i < W; i++) begin
      check("run_busy", 32'(busy), 32'd1);
      check("run_done", 32'(done), 32'd0);
      check("run_sum_hold", 32'(sum), 32'(ha));
      check("run_co_hold", 32'(co), 32'(hco));
      start = noisy ? 1'($urandom_range(1)) : 1'b0;
      a = W'($urandom); b = W'($urandom); ci = 1'($urandom);
      tick();
    end
    start = 1'b0;
    model(oa, ob, oci);
    check("done_pulse", 32'(done), 32'd1);
    check("done_busy", 32'(busy), 32'd0);
    check_held("result");
    if (hb == '1) check("dummy_guard", 32'(done), 32'd1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; ci = 1'b0;
    exp_sum = '0; exp_co = 1'b0;
`ifdef SERIAL_ADD_OVF_EN
    exp_ovf = 1'b0;
`endif
    tick(); tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check_held("rst");
    rst = 1'b0;
    tick();
    check("idle_busy", 32'(busy), 32'd0);

    // Directed cases from the plan.
    run_op(4'd5, 4'd3, 1'b0, 1'b0);
    tick();
    check("idle_after_done", 32'(done), 32'd0);
    check_held("idle_hold");
    run_op(4'd15, 4'd1, 1'b0, 1'b0);
    tick();
    run_op(4'd7, 4'd8, 1'b1, 1'b1);
    tick();
`ifdef SERIAL_ADD_OVF_EN
    run_op(4'd7, 4'd1, 1'b0, 1'b0); tick();
    run_op(4'd8, 4'd8, 1'b0, 1'b0); tick();
`endif

    // Back-to-back: next op accepted in the DONE cycle.
    run_op(4'd2, 4'd2, 1'b0, 1'b1);
    run_op(4'd9, 4'd9, 1'b0, 1'b1);
    tick();

    // Randomized operations with random gaps and noisy start in RUN.
    for (int unsigned n = 0; n < 40; n++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
      if ($urandom_range(1) == 0) begin
        for (int unsigned g = 0; g < $urandom_range(3); g++) begin
          tick();
          check("gap_done", 32'(done), 32'd0);
          check_held("gap");
        end
      end
    end
    tick();

    // Reset on the 2nd RUN cycle aborts without a done pulse.
    start = 1'b1; a = 4'd6; b = 4'd6; ci = 1'b0;
    tick();
    start = 1'b0;
    tick();
    check("mid_busy_pre", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_sum = '0; exp_co = 1'b0;
`ifdef SERIAL_ADD_OVF_EN
    exp_ovf = 1'b0;
`endif
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check_held("abort");
    for (int unsigned i = 0; i < W + 2; i++) begin
      tick();
      check("abort_no_done", 32'(done), 32'd0);
    end

    // rst wins over start.
    run_op(4'd3, 4'd4, 1'b1, 1'b0);
    start = 1'b1; rst = 1'b1;
    tick();
    start = 1'b0; rst = 1'b0;
    exp_sum = '0; exp_co = 1'b0;
`ifdef SERIAL_ADD_OVF_EN
    exp_ovf = 1'b0;
`endif
    check("rst_start_busy", 32'(busy), 32'd0);
    check_held("rst_start");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
